// File: rtl/strait_bist_sequencer.sv
// LBIST sequencer for the STRAIT systolic array: walks the SA/TD eNVM pattern sets,
// compares column partial sums against expected answers and keeps a sticky fault summary.
module strait_bist_sequencer #(
    parameter int unsigned ROWS                   = 8,
    parameter int unsigned COLS                   = 8,
    parameter int unsigned PARTIAL_SUM_WIDTH      = 19,
    parameter int unsigned SA_TEST_PATTERN_DEPTH  = 12,
    parameter int unsigned TD_TEST_PATTERN_DEPTH  = 16,
    parameter int unsigned SCAN_CYCLES            = ROWS,
    parameter int unsigned CAPTURE_LATENCY        = 2,
    parameter int unsigned MAX_PATTERN_ADDR_WIDTH =
        ($clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ? SA_TEST_PATTERN_DEPTH
                                                                : TD_TEST_PATTERN_DEPTH) < 1) ? 1 :
         $clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ? SA_TEST_PATTERN_DEPTH
                                                                : TD_TEST_PATTERN_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  START,
    input  logic [1:0]                            mode_sel,
    input  logic [COLS*PARTIAL_SUM_WIDTH-1:0]     psum_obs_flat,
    input  logic [COLS*PARTIAL_SUM_WIDTH-1:0]     psum_exp_flat,
    output logic                                  test_type,
    output logic [MAX_PATTERN_ADDR_WIDTH-1:0]     test_counter,
    output logic                                  scan_en,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [COLS-1:0]                       col_fault,
    output logic [$clog2(COLS+1)-1:0]             fault_count,
    output logic                                  fail_valid,
    output logic                                  fail_type,
    output logic [MAX_PATTERN_ADDR_WIDTH-1:0]     fail_index
);

    localparam int unsigned W         = PARTIAL_SUM_WIDTH;
    localparam int unsigned AW        = MAX_PATTERN_ADDR_WIDTH;
    localparam int unsigned FC_W      = $clog2(COLS + 1);
    localparam int unsigned PHASE_MAX = (SCAN_CYCLES > CAPTURE_LATENCY) ? SCAN_CYCLES : CAPTURE_LATENCY;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_WAIT    = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [PHASE_W-1:0]   phase, phase_n;
    logic                 run_td, run_td_n;
    logic                 test_type_n, scan_en_n, busy_n, done_n, pass_n;
    logic [AW-1:0]        test_counter_n, fail_index_n;
    logic [COLS-1:0]      col_fault_n, mismatch_c;
    logic                 fail_valid_n, fail_type_n, last_pattern_c;

    // Full-width per-column compare of observed vs expected partial sums
    always_comb begin
        mismatch_c = '0;
        for (int c = 0; c < COLS; c++) begin
            mismatch_c[c] = psum_obs_flat[c*W +: W] != psum_exp_flat[c*W +: W];
        end
    end

    always_comb begin
        fault_count = '0;
        for (int c = 0; c < COLS; c++) begin
            fault_count = fault_count + FC_W'(col_fault[c]);
        end
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_n        = state;
        phase_n        = phase;
        run_td_n       = run_td;
        test_type_n    = test_type;
        test_counter_n = test_counter;
        scan_en_n      = scan_en;
        busy_n         = busy;
        done_n         = 1'b0;
        pass_n         = pass;
        col_fault_n    = col_fault;
        fail_valid_n   = fail_valid;
        fail_type_n    = fail_type;
        fail_index_n   = fail_index;
        last_pattern_c = test_type ? (test_counter == AW'(TD_TEST_PATTERN_DEPTH - 1))
                                   : (test_counter == AW'(SA_TEST_PATTERN_DEPTH - 1));

        case (state)
            S_IDLE: begin
                if (START) begin
                    busy_n       = 1'b1;
                    col_fault_n  = '0;
                    fail_valid_n = 1'b0;
                    fail_type_n  = 1'b0;
                    fail_index_n = '0;
                    if (mode_sel != 2'b00) begin
                        state_n        = S_SCAN;
                        run_td_n       = mode_sel[1];
                        test_type_n    = ~mode_sel[0];
                        test_counter_n = '0;
                        phase_n        = '0;
                        scan_en_n      = 1'b1;
                        pass_n         = 1'b0;
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (phase == PHASE_W'(SCAN_CYCLES - 1)) begin
                    phase_n   = '0;
                    scan_en_n = 1'b0;
                    state_n   = (CAPTURE_LATENCY == 0) ? S_COMPARE : S_WAIT;
                end else begin
                    phase_n = phase + PHASE_W'(1);
                end
            end
            S_WAIT: begin
                if (phase == PHASE_W'(CAPTURE_LATENCY - 1)) begin
                    phase_n = '0;
                    state_n = S_COMPARE;
                end else begin
                    phase_n = phase + PHASE_W'(1);
                end
            end
            S_COMPARE: begin
                col_fault_n = col_fault | mismatch_c;
                if ((mismatch_c != '0) && !fail_valid) begin
                    fail_valid_n = 1'b1;
                    fail_type_n  = test_type;
                    fail_index_n = test_counter;
                end
                if (!last_pattern_c) begin
                    test_counter_n = test_counter + AW'(1);
                    scan_en_n      = 1'b1;
                    state_n        = S_SCAN;
                end else if (!test_type && run_td) begin
                    test_type_n    = 1'b1;
                    test_counter_n = '0;
                    scan_en_n      = 1'b1;
                    state_n        = S_SCAN;
                end else begin
                    done_n  = 1'b1;
                    pass_n  = (col_fault_n == '0);
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase        <= '0;
            run_td       <= 1'b0;
            test_type    <= 1'b0;
            test_counter <= '0;
            scan_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            col_fault    <= '0;
            fail_valid   <= 1'b0;
            fail_type    <= 1'b0;
            fail_index   <= '0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            run_td       <= run_td_n;
            test_type    <= test_type_n;
            test_counter <= test_counter_n;
            scan_en      <= scan_en_n;
            busy         <= busy_n;
            done         <= done_n;
            pass         <= pass_n;
            col_fault    <= col_fault_n;
            fail_valid   <= fail_valid_n;
            fail_type    <= fail_type_n;
            fail_index   <= fail_index_n;
        end
    end

endmodule
